// File: rtl/apb_master_bridge.sv
// APB requester: accepts one command at a time, decodes the target slave from the
// top address bits, runs SETUP/ACCESS and returns a one-cycle response strobe.
module apb_master_bridge #(
    parameter int unsigned DATA_WDTH  = 32,
    parameter int unsigned ADDR_WDTH  = 8,
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                            pclk,
    input  logic                            preset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [ADDR_WDTH-1:0]            cmd_addr,
    input  logic [DATA_WDTH-1:0]            cmd_wdata,
    output logic                            rsp_valid,
    output logic [DATA_WDTH-1:0]            rsp_rdata,
    output logic                            rsp_err,
    output logic                            rsp_timeout,
    output logic [NUM_SLAVES-1:0]           psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [ADDR_WDTH-1:0]            paddr,
    output logic [DATA_WDTH-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_WDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]           pready,
    input  logic [NUM_SLAVES-1:0]           pslverr
);

    localparam int unsigned SEL_W = $clog2(NUM_SLAVES);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic                    rdy_en_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WDTH-1:0]    paddr_q, paddr_d;
    logic [DATA_WDTH-1:0]    pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic [SEL_W-1:0]        cmd_idx;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WDTH-1:0]    sel_rdata;

    // Only the addressed slave's handshake and data are ever looked at.
    assign cmd_idx   = cmd_addr[ADDR_WDTH-1 -: SEL_W];
    assign sel_ready = pready[idx_q];
    assign sel_err   = pslverr[idx_q];
    assign sel_rdata = prdata[idx_q*DATA_WDTH +: DATA_WDTH];

    // cmd_ready stays low during reset and until the first edge after release.
    assign cmd_ready = rdy_en_q && (state_q == IDLE);

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    // Enable cmd_ready from the first clock edge after reset release.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    // State and registered bus/response outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state and next-output decode for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d         = SETUP;
                    pwrite_d        = cmd_write;
                    paddr_d         = cmd_addr;
                    pwdata_d        = cmd_wdata;
                    idx_d           = cmd_idx;
                    psel_d          = '0;
                    psel_d[cmd_idx] = 1'b1;
                    penable_d       = 1'b0;
                    cnt_d           = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A ready on the limit edge still completes normally.
                if (sel_ready) begin
                    state_d       = IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = sel_err;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : sel_rdata;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: slaves are modelled by driving pready,
// pslverr and prdata directly; inputs change and outputs are sampled on negedge.
module tb_apb_master_bridge;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NS = 2;
    localparam int TO = 4;

    logic             pclk = 1'b0;
    logic             preset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [AW-1:0]    cmd_addr = '0;
    logic [DW-1:0]    cmd_wdata = '0;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             rsp_timeout;
    logic [NS-1:0]    psel;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic [NS*DW-1:0] prdata = '0;
    logic [NS-1:0]    pready = '0;
    logic [NS-1:0]    pslverr = '0;

    int            vectors = 0;
    int            miscompares = 0;
    logic [NS-1:0] psel_seen;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .DATA_WDTH (DW),
        .ADDR_WDTH (AW),
        .NUM_SLAVES(NS),
        .TIMEOUT   (TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // Present a command from a negedge until it is accepted (bounded); returns at
    // the negedge right after the accepting edge (SETUP cycle visible).
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin
                @(negedge pclk);
                break;
            end
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
    endtask

    // Count negedges (1 = SETUP cycle) until rsp_valid; -1 if it never arrives.
    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (rsp_valid === 1'b1) begin
                cyc = c;
                break;
            end
            psel_seen |= psel;
            @(negedge pclk);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        vectors++;
        if (cmd_ready !== 1'b0 || psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 1'b0 ||
            paddr !== 8'h00 || pwdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b psel=%b pen=%b rv=%b paddr=%h pwdata=%h err=%b to=%b, required all 0",
                     cmd_ready, psel, penable, rsp_valid, paddr, pwdata, rsp_err, rsp_timeout);
        end
        preset = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_before_edge: got %b required 0", cmd_ready);
        end
        @(negedge pclk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_after_edge: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        pready  = 2'b01;
        pslverr = 2'b00;
        prdata  = {32'h0, 32'h11111111};
        issue(1'b1, 8'h05, 32'hA1B2C3D4);
        vectors++;
        if (psel !== 2'b01 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 8'h05 ||
            pwdata !== 32'hA1B2C3D4 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_setup: psel=%b pen=%b pw=%b paddr=%h pwdata=%h ready=%b, required 01 0 1 05 a1b2c3d4 0",
                     psel, penable, pwrite, paddr, pwdata, cmd_ready);
        end
        @(negedge pclk);
        vectors++;
        if (psel !== 2'b01 || penable !== 1'b1 || paddr !== 8'h05) begin
            miscompares++;
            $display("FAIL wr_access: psel=%b pen=%b paddr=%h, required 01 1 05", psel, penable, paddr);
        end
        @(negedge pclk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0 ||
            psel !== 2'b00 || penable !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rsp: rv=%b err=%b to=%b rdata=%h psel=%b pen=%b, required 1 0 0 0 00 0",
                     rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, penable);
        end
        @(negedge pclk);
        vectors++;
        if (rsp_valid !== 1'b0 || paddr !== 8'h05 || pwrite !== 1'b1 || pwdata !== 32'hA1B2C3D4 ||
            cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_idle_hold: rv=%b paddr=%h pw=%b pwdata=%h ready=%b, required 0 05 1 a1b2c3d4 1",
                     rsp_valid, paddr, pwrite, pwdata, cmd_ready);
        end
    endtask

    task automatic test_read_wait();
        int c;
        int pen;
        pready    = 2'b01;
        pslverr   = 2'b00;
        prdata    = {32'hDEADBEEF, 32'h12345678};
        psel_seen = '0;
        issue(1'b0, 8'h85, 32'h0);
        c   = 1;
        pen = 0;
        while (c <= 30 && rsp_valid !== 1'b1) begin
            if (penable === 1'b1) pen++;
            psel_seen |= psel;
            if (c == 4) pready = 2'b11;
            @(negedge pclk);
            c++;
        end
        vectors++;
        if (c != 5 || pen != 3) begin
            miscompares++;
            $display("FAIL rd_latency: rsp at %0d penable cycles %0d, required 5 and 3", c, pen);
        end
        vectors++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || psel_seen !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_data: rdata=%h err=%b to=%b psel_seen=%b, required deadbeef 0 0 10",
                     rsp_rdata, rsp_err, rsp_timeout, psel_seen);
        end
        @(negedge pclk);
    endtask

    task automatic test_slverr();
        int cyc;
        pready  = 2'b11;
        pslverr = 2'b01;
        issue(1'b1, 8'h10, 32'h0F0F0F0F);
        wait_rsp(cyc);
        vectors++;
        if (cyc != 3 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL slverr_own: cyc=%0d err=%b to=%b, required 3 1 0", cyc, rsp_err, rsp_timeout);
        end
        @(negedge pclk);
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL slverr_hold: rv=%b err=%b, required 0 1", rsp_valid, rsp_err);
        end
        pslverr = 2'b10;
        issue(1'b1, 8'h11, 32'h1);
        wait_rsp(cyc);
        vectors++;
        if (cyc != 3 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL slverr_other_ignored: cyc=%0d err=%b to=%b, required 3 0 0", cyc, rsp_err, rsp_timeout);
        end
        pslverr = 2'b00;
        @(negedge pclk);
    endtask

    task automatic test_timeout();
        int c;
        int pen;
        prdata  = {32'hCAFEF00D, 32'h0};
        pslverr = 2'b00;
        for (int v = 0; v < 2; v++) begin
            pready = 2'b00;
            issue(1'b0, 8'h80, 32'h0);
            c   = 1;
            pen = 0;
            while (c <= 30 && rsp_valid !== 1'b1) begin
                if (penable === 1'b1) pen++;
                if (v == 1 && c == 5) pready = 2'b10;
                @(negedge pclk);
                c++;
            end
            vectors++;
            if (c != 6 || pen != 4 || psel !== 2'b00 || penable !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_len_v%0d: rsp at %0d penable cycles %0d psel=%b pen=%b, required 6 4 00 0",
                         v, c, pen, psel, penable);
            end
            vectors++;
            if (v == 0 && (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0)) begin
                miscompares++;
                $display("FAIL timeout_abort: err=%b to=%b rdata=%h, required 1 1 0", rsp_err, rsp_timeout, rsp_rdata);
            end
            if (v == 1 && (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFEF00D)) begin
                miscompares++;
                $display("FAIL timeout_ready_at_limit: err=%b to=%b rdata=%h, required 0 0 cafef00d",
                         rsp_err, rsp_timeout, rsp_rdata);
            end
            @(negedge pclk);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic          ws [3];
        logic [DW-1:0] exp_rd [3];
        int            acc [3];
        int            n_acc;
        int            n_rsp;
        int            k;
        bit            upd;
        addrs   = '{8'h04, 8'hC8, 8'h3C};
        ws      = '{1'b0, 1'b0, 1'b1};
        exp_rd  = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0};
        acc     = '{0, 0, 0};
        pready  = 2'b11;
        pslverr = 2'b00;
        prdata  = {32'hB1B1B1B1, 32'hA0A0A0A0};
        n_acc = 0;
        n_rsp = 0;
        k     = 0;
        upd   = 0;
        cmd_write = ws[0];
        cmd_addr  = addrs[0];
        cmd_wdata = 32'h77;
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (rsp_valid === 1'b1) begin
                vectors++;
                if (n_rsp >= 3) begin
                    miscompares++;
                    $display("FAIL b2b_extra_rsp: response %0d, required only 3", n_rsp);
                end else if (rsp_rdata !== exp_rd[n_rsp] || paddr !== addrs[n_rsp]) begin
                    miscompares++;
                    $display("FAIL b2b_rsp%0d: rdata=%h paddr=%h, required %h %h",
                             n_rsp, rsp_rdata, paddr, exp_rd[n_rsp], addrs[n_rsp]);
                end
                n_rsp++;
            end
            if (upd) begin
                k++;
                upd = 0;
                if (k < 3) begin
                    cmd_write = ws[k];
                    cmd_addr  = addrs[k];
                    cmd_wdata = 32'h77 + k;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                if (n_acc < 3) acc[n_acc] = cyc;
                n_acc++;
                upd = 1;
            end
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        vectors++;
        if (n_acc != 3 || n_rsp != 3 || acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
            miscompares++;
            $display("FAIL b2b_spacing: accepts=%0d rsps=%0d at %0d,%0d,%0d, required 3 3 spaced by 3",
                     n_acc, n_rsp, acc[0], acc[1], acc[2]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        pready  = 2'b00;
        pslverr = 2'b00;
        issue(1'b1, 8'h90, 32'h5555AAAA);
        @(negedge pclk);
        vectors++;
        if (penable !== 1'b1 || psel !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_pre_access: pen=%b psel=%b, required 1 10", penable, psel);
        end
        #2 preset = 1'b1;
        #1;
        vectors++;
        if (psel !== 2'b00 || penable !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async_drop: psel=%b pen=%b ready=%b rv=%b, required 00 0 0 0",
                     psel, penable, cmd_ready, rsp_valid);
        end
        @(negedge pclk);
        preset = 1'b0;
        pready = 2'b11;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) n++;
        end
        vectors++;
        if (n != 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_no_rsp: rsp strobes=%0d ready=%b, required 0 1", n, cmd_ready);
        end
        prdata = {32'h0, 32'h600DF00D};
        issue(1'b0, 8'h22, 32'h0);
        wait_rsp(cyc);
        vectors++;
        if (cyc != 3 || rsp_rdata !== 32'h600DF00D || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_next_cmd: cyc=%0d rdata=%h err=%b to=%b, required 3 600df00d 0 0",
                     cyc, rsp_rdata, rsp_err, rsp_timeout);
        end
        @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
